output_drain_controller: RTL and testbench

OUTPUT_DRAIN_CONTROLLER -- requirements
Module: output_drain_controller

---
 rtl/outmem_pkg.sv | 17 +
 rtl/out_skid_fifo.sv | 66 ++++++
 rtl/output_drain_controller.sv | 143 ++++++++++++++
 tb/tb_output_drain_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/outmem_pkg.sv
// Shared state encoding and output-buffer sizing for output_drain_controller.
package outmem_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int BUF_IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  function automatic logic [BUF_IDX_W-1:0] next_idx(input logic [BUF_IDX_W-1:0] idx);
    return (idx == BUF_IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + BUF_IDX_W'(1);
  endfunction

endpackage

// File: rtl/out_skid_fifo.sv
// Small register FIFO holding read data on its way to the consumer.
// Same-cycle push and pop leave the occupancy unchanged.
module out_skid_fifo
  import outmem_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [BUF_CNT_W-1:0] count
);

  logic [DATA_SIZE-1:0] entry_q [BUF_DEPTH];
  logic [DATA_SIZE-1:0] entry_d [BUF_DEPTH];
  logic [BUF_IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [BUF_IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [BUF_CNT_W-1:0] count_q, count_d;
  logic                 push_ok;
  logic                 pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A full buffer can still accept a word when the head leaves this cycle.
    push_ok  = push && ((count_q != BUF_CNT_W'(BUF_DEPTH)) || pop_ok);
    wr_idx_d = push_ok ? next_idx(wr_idx_q) : wr_idx_q;
    rd_idx_d = pop_ok ? next_idx(rd_idx_q) : rd_idx_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + BUF_CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - BUF_CNT_W'(1);
    end
    for (int i = 0; i < BUF_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (push_ok && (wr_idx_q == BUF_IDX_W'(i))) begin
        entry_d[i] = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = entry_q[rd_idx_q];
  assign count     = count_q;

endmodule

// File: rtl/output_drain_controller.sv
// Fills a frame buffer from a producer, then drains it to a consumer through a 2-entry buffer.
// Optional: define OUTMEM_OVERFLOW_FLAG_EN to add a sticky overflow output.
module output_drain_controller
  import outmem_pkg::*;
#(
  parameter int ADD_SIZE    = 11,
  parameter int DATA_SIZE   = 32,
  parameter int FRAME_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] dataIn,
  output logic                 mem_write_en,
  output logic [ADD_SIZE-1:0]  mem_write_address,
  output logic [DATA_SIZE-1:0] mem_write_data,
  output logic                 mem_read_en,
  output logic [ADD_SIZE-1:0]  mem_read_address,
  input  logic [DATA_SIZE-1:0] mem_read_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] dataOut,
  output logic                 frame_done
`ifdef OUTMEM_OVERFLOW_FLAG_EN
  ,
  output logic                 overflow
`endif
);

  localparam logic [ADD_SIZE:0] LAST_ADDR = (ADD_SIZE + 1)'(FRAME_WORDS - 1);
  localparam logic [ADD_SIZE:0] FRAME_END = (ADD_SIZE + 1)'(FRAME_WORDS);

  state_e              state_q, state_d;
  logic [ADD_SIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [ADD_SIZE:0]   rd_ptr_q, rd_ptr_d;
  logic                rd_inflight_q, rd_inflight_d;
  logic                frame_done_q, frame_done_d;

  logic                wr_fire;
  logic                rd_fire;
  logic                read_budget_ok;
  logic                last_pop;
  logic                buf_valid;
  logic                buf_pop;
  logic [DATA_SIZE-1:0] buf_data;
  logic [BUF_CNT_W-1:0] buf_count;

  out_skid_fifo #(
    .DATA_SIZE (DATA_SIZE)
  ) u_out_skid_fifo (
    .clk       (clk),
    .srst      (rst),
    .push      (rd_inflight_q),
    .push_data (mem_read_data),
    .pop       (buf_pop),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .count     (buf_count)
  );

  always_comb begin
    in_ready  = (state_q == FILL) && !rst;
    wr_fire   = in_valid && in_ready;
    out_valid = buf_valid && !rst;
    buf_pop   = out_valid && out_ready;

    // Count the slot freed by a same-cycle pop so a steady drain sustains one word per cycle.
    read_budget_ok = (int'(buf_count) + int'(rd_inflight_q) - int'(buf_pop)) < BUF_DEPTH;
    rd_fire = (state_q == DRAIN) && !rst && (rd_ptr_q < FRAME_END) && read_budget_ok;

    // The final word is leaving when every read is issued, none is pending and one word remains.
    last_pop = buf_pop && (state_q == DRAIN) && (rd_ptr_q == FRAME_END)
               && !rd_inflight_q && (buf_count == BUF_CNT_W'(1));

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_inflight_d = rd_fire;
    frame_done_d  = last_pop;

    if (wr_fire) begin
      if (wr_ptr_q == LAST_ADDR) begin
        wr_ptr_d = '0;
        state_d  = DRAIN;
      end else begin
        wr_ptr_d = wr_ptr_q + (ADD_SIZE + 1)'(1);
      end
    end

    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + (ADD_SIZE + 1)'(1);
    end

    if (last_pop) begin
      rd_ptr_d = '0;
      state_d  = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_inflight_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_inflight_q <= rd_inflight_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign mem_write_en      = wr_fire;
  assign mem_write_address = wr_fire ? wr_ptr_q[ADD_SIZE-1:0] : '0;
  assign mem_write_data    = wr_fire ? dataIn : '0;
  assign mem_read_en       = rd_fire;
  assign mem_read_address  = rd_fire ? rd_ptr_q[ADD_SIZE-1:0] : '0;
  assign dataOut           = out_valid ? buf_data : '0;
  assign frame_done        = frame_done_q && !rst;

`ifdef OUTMEM_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q || (in_valid && (state_q == DRAIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_output_drain_controller.sv
// Self-checking bench for output_drain_controller with a 4-word frame and a 1-cycle-read memory model.
// Define OUTMEM_OVERFLOW_FLAG_EN to also check the overflow flag.
module tb_output_drain_controller;

  localparam int ADD_SIZE  = 2;
  localparam int DATA_SIZE = 32;
  localparam int FW        = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] dataIn = '0;
  logic                 mem_write_en;
  logic [ADD_SIZE-1:0]  mem_write_address;
  logic [DATA_SIZE-1:0] mem_write_data;
  logic                 mem_read_en;
  logic [ADD_SIZE-1:0]  mem_read_address;
  logic [DATA_SIZE-1:0] mem_read_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DATA_SIZE-1:0] dataOut;
  logic                 frame_done;
`ifdef OUTMEM_OVERFLOW_FLAG_EN
  logic                 overflow;
`endif

  output_drain_controller #(
    .ADD_SIZE    (ADD_SIZE),
    .DATA_SIZE   (DATA_SIZE),
    .FRAME_WORDS (FW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .dataIn            (dataIn),
    .mem_write_en      (mem_write_en),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_en       (mem_read_en),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .dataOut           (dataOut),
    .frame_done        (frame_done)
`ifdef OUTMEM_OVERFLOW_FLAG_EN
    ,
    .overflow          (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Frame memory: data is only meaningful the cycle after a read strobe, garbage otherwise.
  logic [DATA_SIZE-1:0] mem [FW];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_address] <= mem_write_data;
    mem_read_data <= mem_read_en ? mem[mem_read_address] : $urandom;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: words written in order must come out in the same order.
  bit          m_fill;
  bit          m_done_pending;
  bit          m_sustained;
  bit          m_prev_stall;
  bit          m_ovf;
  int          m_wcount;
  int          m_pops;
  int          m_k;
  int          m_frames;
  logic [31:0] m_prev_data;
  logic [31:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fill = 1'b1;
    m_done_pending = 1'b0;
    m_sustained = 1'b0;
    m_prev_stall = 1'b0;
    m_ovf = 1'b0;
    m_wcount = 0;
    m_pops = 0;
    m_k = 0;
    m_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dataIn = '0;
    #1;
    check("rst_in_ready_first", 32'(in_ready), 32'(0));
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_wr_en", 32'(mem_write_en), 32'(0));
    check("rst_rd_en", 32'(mem_read_en), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_dataOut", dataOut, 32'(0));
    check("rst_wr_addr", 32'(mem_write_address), 32'(0));
    check("rst_rd_addr", 32'(mem_read_address), 32'(0));
`ifdef OUTMEM_OVERFLOW_FLAG_EN
    check("rst_overflow", 32'(overflow), 32'(0));
`endif
    model_reset();
  endtask

  task automatic step(input logic iv, input logic [31:0] din, input logic ordy);
    bit          was_fill;
    logic [31:0] exp;
    @(negedge clk);
    rst = 1'b0; in_valid = iv; dataIn = din; out_ready = ordy;
    #1;
    was_fill = m_fill;
    check("rd_wr_exclusive", 32'(mem_read_en & mem_write_en), 32'(0));
    check("frame_done", 32'(frame_done), 32'(m_done_pending));
    if (m_done_pending) begin
      m_frames++;
      m_done_pending = 1'b0;
    end
    check("in_ready", 32'(in_ready), 32'(was_fill));
    if (was_fill && iv) begin
      check("wr_en", 32'(mem_write_en), 32'(1));
      check("wr_addr", 32'(mem_write_address), 32'(m_wcount));
      check("wr_data", mem_write_data, din);
      m_q.push_back(din);
      m_wcount++;
      if (m_wcount == FW) begin
        m_fill = 1'b0; m_wcount = 0; m_pops = 0; m_k = 0;
        m_sustained = 1'b1; m_prev_stall = 1'b0;
      end
    end else begin
      check("wr_en_idle", 32'(mem_write_en), 32'(0));
    end
    if (was_fill) begin
      check("out_valid_fill", 32'(out_valid), 32'(0));
    end else begin
      m_sustained = m_sustained && ordy;
      if (m_sustained)
        check("drain_timing", 32'(out_valid), 32'(m_k >= 2 && m_k < 2 + FW));
      if (m_prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'(1));
        check("stall_data", dataOut, m_prev_data);
      end
      if (out_valid && ordy) begin
        check("word_expected", 32'(m_q.size() != 0), 32'(1));
        if (m_q.size() != 0) begin
          exp = m_q.pop_front();
          check("dataOut", dataOut, exp);
        end
        m_pops++;
        if (m_pops == FW) begin
          m_done_pending = 1'b1;
          m_fill = 1'b1;
        end
      end
      m_prev_stall = out_valid && !ordy;
      m_prev_data = dataOut;
      m_k++;
    end
`ifdef OUTMEM_OVERFLOW_FLAG_EN
    m_ovf = m_ovf || (iv && !was_fill);
    check("overflow", 32'(overflow), 32'(m_ovf));
`endif
  endtask

  // rdy_mode: 0 = always ready, 1 = ready pattern 1,0,0 repeating during drain, 2 = random.
  task automatic run_frame(input logic [31:0] base, input bit rnd_data, input bit rnd_valid,
                           input int rdy_mode, input bit hold_drain_valid);
    int          start;
    int          c;
    int          dk;
    logic        iv;
    logic [31:0] d;
    logic        r;
    start = m_frames; c = 0; dk = 0;
    while (m_frames == start && c < 300) begin
      if (m_fill && !m_done_pending) begin
        iv = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        d  = rnd_data ? $urandom : base + 32'(m_wcount);
      end else if (m_done_pending) begin
        iv = 1'b0;
        d  = $urandom;
      end else begin
        iv = hold_drain_valid || (rnd_valid && ($urandom_range(0, 3) == 0));
        d  = $urandom;
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (dk % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (!m_fill) dk++;
      step(iv, d, r);
      c++;
    end
    check("frame_complete", 32'(m_frames - start), 32'(1));
  endtask

  initial begin
    m_frames = 0;
    model_reset();
    do_reset();

    // Back-to-back fill, always-ready drain
    run_frame(32'hA0, 1'b0, 1'b0, 0, 1'b0);
    // Drain with stalls
    run_frame(32'hA0, 1'b0, 1'b0, 1, 1'b0);
    // Producer keeps pushing while draining
    run_frame(32'hB0, 1'b0, 1'b0, 0, 1'b1);

    // Reset after two words, then the next word must land at address 0
    step(1'b1, 32'hC0, 1'b1);
    step(1'b1, 32'hC1, 1'b1);
    do_reset();
    run_frame(32'hC8, 1'b0, 1'b0, 0, 1'b0);

    // Reset in the middle of a stalled drain
    for (int i = 0; i < FW; i++) step(1'b1, 32'hD0 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 1'b1);

    // Two consecutive frames
    run_frame(32'h10, 1'b0, 1'b0, 0, 1'b0);
    run_frame(32'h20, 1'b0, 1'b0, 0, 1'b0);

    // Random data, producer gaps and consumer back-pressure
    for (int f = 0; f < 6; f++) run_frame(32'h0, 1'b1, 1'b1, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
